// File: rtl/demux_sched.sv
// Round-robin 1:4 demux scheduler with a single-entry output register.
// Define DEMUX_SCHED_BURST_EN to keep every beat of a packet on one channel.
module demux_sched #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [3:0]   chan_mask,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         in_last,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic [3:0]   out_valid,
   input  logic [3:0]   out_ready,
   output logic [1:0]   sel
);

   logic         full_q, full_d;
   logic [W-1:0] data_q, data_d;
   logic [1:0]   sel_q, sel_d;
   logic [1:0]   ptr_q, ptr_d;
   logic [1:0]   pick;
   logic [1:0]   target;
   logic         found;
   logic         drain;
   logic         accept;

   assign drain    = full_q && out_ready[sel_q];
   assign in_ready = en && (chan_mask != 4'b0000) && (!full_q || out_ready[sel_q]);
   assign accept   = in_valid && in_ready;

   assign out_data  = data_q;
   assign sel       = sel_q;
   assign out_valid = full_q ? (4'b0001 << sel_q) : 4'b0000;

   // First eligible channel scanning upward from the rotation pointer.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!found && chan_mask[ptr_q + 2'(i)]) begin
            pick  = ptr_q + 2'(i);
            found = 1'b1;
         end
      end
   end

`ifdef DEMUX_SCHED_BURST_EN
   logic       locked_q, locked_d;
   logic [1:0] lock_sel_q, lock_sel_d;

   assign target = locked_q ? lock_sel_q : pick;

   always_comb begin
      full_d     = full_q;
      data_d     = data_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      locked_d   = locked_q;
      lock_sel_d = lock_sel_q;
      if (accept) begin
         full_d = 1'b1;
         data_d = in_data;
         sel_d  = target;
         // Pointer only moves on packet boundaries; mid-packet the target stays pinned.
         if (in_last) begin
            ptr_d    = target + 2'd1;
            locked_d = 1'b0;
         end else begin
            locked_d   = 1'b1;
            lock_sel_d = target;
         end
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_q   <= 1'b0;
         lock_sel_q <= 2'd0;
      end else begin
         locked_q   <= locked_d;
         lock_sel_q <= lock_sel_d;
      end
   end
`else
   logic unused_last;

   assign target      = pick;
   assign unused_last = in_last;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      sel_d  = sel_q;
      ptr_d  = ptr_q;
      if (accept) begin
         full_d = 1'b1;
         data_d = in_data;
         sel_d  = target;
         ptr_d  = target + 2'd1;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
         sel_q  <= 2'd0;
         ptr_q  <= 2'd0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         sel_q  <= sel_d;
         ptr_q  <= ptr_d;
      end
   end

endmodule

// File: doc/demux_sched.md
DEMUX_SCHED -- requirements
Module: demux_sched

Interface
REQ-001 Parameter W, default 8, width of the data beat steered to the four channels.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  scheduler enable; low blocks new acceptance.
REQ-005 chan_mask  input  4  per-channel enable; bit k=1 means channel k is eligible for dispatch.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_data  input  W  upstream beat payload.
REQ-008 in_last  input  1  marks final beat of a packet.
REQ-009 in_ready  output  1  upstream beat accepted when in_valid&&in_ready at clock edge.
REQ-010 out_data  output  W  shared payload bus to all four channels.
REQ-011 out_valid  output  4  one-hot valid; bit k set means the beat targets channel k.
REQ-012 out_ready  input  4  per-channel ready; channel k consumes when out_valid[k]&&out_ready[k].
REQ-013 sel  output  2  channel index of the held beat (sel=1 selects channel 1, ..., sel=3 selects channel 3); drives the 1:4 demux select pair.

Function
REQ-014 Block SHALL hold a single-entry output register (full flag, data, sel); out_valid SHALL equal full ? (1<<sel) : 0.
REQ-015 Drain: held beat SHALL be consumed when full&&out_ready[sel]; other channels' ready SHALL be ignored.
REQ-016 in_ready SHALL be combinational: en && (chan_mask!=0) && (!full || out_ready[sel]).
REQ-017 Accept latency SHALL be 1 cycle: beat accepted at edge N is presented on out_data/out_valid after edge N; sustained throughput SHALL be one beat per cycle when the target is ready.
REQ-018 Rotation pointer ptr[1:0] SHALL name the next candidate channel; target of an accepted beat SHALL be the first index in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with chan_mask bit set.
REQ-019 On accept with target t, ptr SHALL advance to (t+1) mod 4 (subject to REQ-028); wrap from 3 to 0 SHALL be seamless.
REQ-020 Simultaneous drain and accept in one cycle SHALL replace the held beat with the new beat, full remaining 1.
REQ-021 Drain without accept SHALL clear full; accept into empty register SHALL set full.
REQ-022 chan_mask==0 SHALL force in_ready=0; held beat SHALL still drain.
REQ-023 en low or chan_mask changes SHALL never alter a beat already held; mask is sampled only at accept.
REQ-024 No beat SHALL be dropped or duplicated; out_data and sel SHALL be stable while full and not drained.

Reset
REQ-025 While rst_n=0: full=0, out_valid=0000, sel=0, ptr=0, out_data=0, burst-hold state cleared; asynchronous assertion, release synchronous to clk.
REQ-026 Reset mid-transfer SHALL discard the held beat with no channel handshake completing.

Configuration
REQ-027 Macro DEMUX_SCHED_BURST_EN selects packet-granular scheduling.
REQ-028 Without DEMUX_SCHED_BURST_EN: ptr advances after every accepted beat (beat round-robin). With it: target is locked for all beats of a packet, ignoring chan_mask after the first beat, and ptr advances only when a beat with in_last=1 is accepted.

Verification
REQ-029 Reset, chan_mask=1111, en=1, in_valid=1, four beats 0xA0..0xA3, all out_ready=1 -> out_valid 0001,0010,0100,1000 on consecutive cycles, sel 0..3, then wraps to 0001.
REQ-030 chan_mask=0101, six beats -> targets 0,2,0,2,0,2; channels 1,3 never valid.
REQ-031 Held beat to channel 2 with out_ready[2]=0 for 3 cycles, out_ready[0,1,3]=1 -> in_ready=0, out_data/sel stable 3 cycles, drains on 4th.
REQ-032 chan_mask=0000 with in_valid=1 -> in_ready=0, out_valid=0000 after pending beat drains; en=0 same result.
REQ-033 rst_n pulsed low while full with out_ready=0 -> out_valid=0000 immediately, next beat goes to channel 0.
REQ-034 DEMUX_SCHED_BURST_EN defined, packets of length 3 and 2 -> beats 1-3 to channel 0, beats 4-5 to channel 1; undefined -> targets 0,1,2,3,0.
